layer2_aggregator: RTL

LAYER2_AGGREGATOR -- requirements
Module: layer2_aggregator

---
 rtl/layer2_aggregator_pkg.sv | 33 +++
 rtl/sat_accum16.sv | 44 ++++
 rtl/layer2_aggregator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/layer2_aggregator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : layer2_aggregator_pkg
// Purpose : Shared constants, FSM state encoding and the saturating-add
//           helper used by the two-layer counter aggregator.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package layer2_aggregator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } agg_state_e;

  localparam int AGG_DIVISOR = 3;   // layer-1 width in bits
  localparam int AGG_GROUP   = 8;   // layer-1 counters per layer-2 counter
  localparam int CNT_W       = 32;  // raw counter width
  localparam int L1_ADDR_W   = 10;
  localparam int L2_ADDR_W   = 7;
  localparam int SUM_W       = 16;

  // Unsigned add that pins at all-ones instead of wrapping.
  function automatic logic [SUM_W-1:0] sat_add16(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

endpackage : layer2_aggregator_pkg
`default_nettype wire

// File: rtl/sat_accum16.sv
`default_nettype none
// ============================================================================
// Module  : sat_accum16
// Purpose : 16-bit saturating accumulator with synchronous clear and
//           add-enable. Clear has priority over add.
// Ports   : clk_i, rst_i (async, active-high), clr_i, add_en_i, add_i[15:0]
//           sum_o      - registered running sum
//           sum_next_o - sum_o + add_i (saturated), valid the same cycle
// Rev     : 1.0  initial release
// ============================================================================
module sat_accum16
  import layer2_aggregator_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             add_en_i,
  input  logic [SUM_W-1:0] add_i,
  output logic [SUM_W-1:0] sum_o,
  output logic [SUM_W-1:0] sum_next_o
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  assign sum_next_o = sat_add16(sum_q, add_i);
  assign sum_o      = sum_q;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_next_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

endmodule : sat_accum16
`default_nettype wire

// File: rtl/layer2_aggregator.sv
`default_nettype none
// ============================================================================
// Module  : layer2_aggregator
// Purpose : Splits each raw sketch counter into a DIVISOR-bit layer-1 value
//           plus overflow flag, and sums the high parts of every GROUP
//           consecutive counters into a saturating 16-bit layer-2 value.
//           Emits write strobes for external layer-1 / layer-2 RAMs.
// Ports   : Clk, Reset (async, active-high), Start (frame open pulse)
//           In_Valid/In_Counter/In_Ready - counter stream handshake
//           L1_Wren/L1_Addr/L1_Data/L1_Ind - layer-1 write port
//           L2_Wren/L2_Addr/L2_Data        - layer-2 write port
//           Done - one-cycle end-of-frame pulse
// Rev     : 1.0  initial release
// ============================================================================
module layer2_aggregator
  import layer2_aggregator_pkg::*;
#(
  parameter int NUM_COUNTER = 10,
  parameter int NUM_SLICE   = 3,
  parameter int DIVISOR     = AGG_DIVISOR,
  parameter int GROUP       = AGG_GROUP
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 In_Valid,
  input  logic [CNT_W-1:0]     In_Counter,
  output logic                 In_Ready,
  output logic                 L1_Wren,
  output logic [L1_ADDR_W-1:0] L1_Addr,
  output logic [DIVISOR-1:0]   L1_Data,
  output logic                 L1_Ind,
  output logic                 L2_Wren,
  output logic [L2_ADDR_W-1:0] L2_Addr,
  output logic [SUM_W-1:0]     L2_Data,
  output logic                 Done
);

  localparam int TOTAL = NUM_COUNTER * NUM_SLICE;
  localparam int GCW   = (GROUP > 1) ? $clog2(GROUP) : 1;

  agg_state_e           state_q, state_d;
  logic [L1_ADDR_W-1:0] idx_q, idx_d;
  logic [GCW-1:0]       gcnt_q, gcnt_d;
  logic [L2_ADDR_W-1:0] gidx_q, gidx_d;

  logic                 l1_wren_q, l1_wren_d;
  logic [L1_ADDR_W-1:0] l1_addr_q, l1_addr_d;
  logic [DIVISOR-1:0]   l1_data_q, l1_data_d;
  logic                 l1_ind_q,  l1_ind_d;
  logic                 l2_wren_q, l2_wren_d;
  logic [L2_ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [SUM_W-1:0]     l2_data_q, l2_data_d;

  logic                 acc_clr;
  logic                 accept;
  logic                 is_last;
  logic                 grp_close;
  logic [CNT_W-1:0]     hi_part;
  logic [SUM_W-1:0]     hi_clip;
  logic [SUM_W-1:0]     acc_sum;
  logic [SUM_W-1:0]     acc_sum_next;

  assign In_Ready  = (state_q == ST_RUN);
  assign accept    = In_Valid && In_Ready;
  assign hi_part   = In_Counter >> DIVISOR;
  // Anything at or above 2^16 in the high part contributes a full-scale add.
  assign hi_clip   = (|hi_part[CNT_W-1:SUM_W]) ? {SUM_W{1'b1}} : hi_part[SUM_W-1:0];
  assign is_last   = (idx_q == L1_ADDR_W'(TOTAL - 1));
  assign grp_close = (gcnt_q == GCW'(GROUP - 1)) || is_last;

  sat_accum16 u_acc (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .clr_i      (acc_clr),
    .add_en_i   (accept),
    .add_i      (hi_clip),
    .sum_o      (acc_sum),
    .sum_next_o (acc_sum_next)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gcnt_d    = gcnt_q;
    gidx_d    = gidx_q;
    acc_clr   = 1'b0;
    l1_wren_d = 1'b0;
    l1_addr_d = '0;
    l1_data_d = '0;
    l1_ind_d  = 1'b0;
    l2_wren_d = 1'b0;
    l2_addr_d = '0;
    l2_data_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          gcnt_d  = '0;
          gidx_d  = '0;
          acc_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          l1_wren_d = 1'b1;
          l1_addr_d = idx_q;
          l1_data_d = In_Counter[DIVISOR-1:0];
          l1_ind_d  = |hi_part;
          if (grp_close) begin
            // Sum includes this element; accumulator restarts for the next.
            l2_wren_d = 1'b1;
            l2_addr_d = gidx_q;
            l2_data_d = acc_sum_next;
            gcnt_d    = '0;
            gidx_d    = gidx_q + 1'b1;
            acc_clr   = 1'b1;
          end else begin
            gcnt_d    = gcnt_q + 1'b1;
          end
          if (is_last) state_d = ST_DONE;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gcnt_q    <= '0;
      gidx_q    <= '0;
      l1_wren_q <= 1'b0;
      l1_addr_q <= '0;
      l1_data_q <= '0;
      l1_ind_q  <= 1'b0;
      l2_wren_q <= 1'b0;
      l2_addr_q <= '0;
      l2_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      gidx_q    <= gidx_d;
      l1_wren_q <= l1_wren_d;
      l1_addr_q <= l1_addr_d;
      l1_data_q <= l1_data_d;
      l1_ind_q  <= l1_ind_d;
      l2_wren_q <= l2_wren_d;
      l2_addr_q <= l2_addr_d;
      l2_data_q <= l2_data_d;
    end
  end

  assign L1_Wren = l1_wren_q;
  assign L1_Addr = l1_addr_q;
  assign L1_Data = l1_data_q;
  assign L1_Ind  = l1_ind_q;
  assign L2_Wren = l2_wren_q;
  assign L2_Addr = l2_addr_q;
  assign L2_Data = l2_data_q;
  // The final writes land the cycle after the last accept, which is DONE.
  assign Done    = (state_q == ST_DONE);

  // Registered running sum is kept for observability only.
  logic unused_ok;
  assign unused_ok = ^acc_sum;

endmodule : layer2_aggregator
`default_nettype wire
